// File: rtl/udp_tx_framer.sv
// udp_tx_framer: on start, emits the 8-byte UDP header as two 32-bit words.
// It then pulls ceil(payload_len/4) words from the payload buffer and streams
// them toward the IP/MAC TX path on a valid/ready word interface. A 2-entry
// output queue absorbs the buffer's one-cycle read latency under backpressure.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, src_port, dst_port,      datagram request; fields are latched when
//   payload_len                     start is accepted in IDLE
//   busy, done, err_len             status: busy, end-of-datagram pulse,
//                                   rejected-length pulse
//   buf_rd_en, buf_data,            payload buffer read port; data arrives
//   buf_data_av                     one cycle after the read request
//   out_data, out_valid, out_ready, output word stream, big-endian bytes
//   out_last, out_keep
module udp_tx_framer #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 65507,
  parameter logic [15:0] CHECKSUM_VALUE    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        buf_rd_en,
  input  logic [31:0] buf_data,
  input  logic        buf_data_av,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  out_keep
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PORT_W  = 16;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned LENX_W  = LEN_W + 1;
  localparam int unsigned CNT_W   = LENX_W - 2;
  localparam int unsigned CNTX_W  = CNT_W + 1;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned OCC_W   = 2;
  localparam int unsigned OCCX_W  = OCC_W + 1;
  localparam int unsigned UDP_HDR_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    PAY  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [KEEP_W-1:0] keep;
  } q_entry_t;

  state_t            state;
  state_t            state_nxt;

  logic [PORT_W-1:0] src_q;
  logic [PORT_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  recv_cnt;
  logic [CNT_W-1:0]  total_words;
  logic [LENX_W-1:0] len_round;
  logic              inflight;

  q_entry_t          q_head;
  q_entry_t          q_tail;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_after_pop;
  logic [OCC_W-1:0]  occ_nxt;

  logic              pop;
  logic              push;
  q_entry_t          push_entry;
  logic              room;
  logic              pay_push;
  logic              last_pay;
  logic              last_hs;
  logic              len_too_big;
  logic              start_ok;
  logic              start_bad;
  logic [KEEP_W-1:0] last_keep;
  logic              rd_words_left;
  logic              rd_space;

  // Request qualification
  assign len_too_big = (LENX_W'(payload_len) > LENX_W'(MAX_PAYLOAD_BYTES));
  assign start_ok    = (state == IDLE) & start & ~len_too_big;
  assign start_bad   = (state == IDLE) & start & len_too_big;

  // Queue bookkeeping; room is judged after this cycle's pop
  assign pop           = (occ != '0) & out_ready;
  assign occ_after_pop = occ - OCC_W'(pop);
  assign room          = (occ_after_pop != OCC_W'(2));

  // Payload word count, ceil(len/4) in 17-bit arithmetic
  assign len_round   = LENX_W'(len_q) + LENX_W'(3);
  assign total_words = len_round[LENX_W-1:2];
  assign last_pay    = (recv_cnt == (total_words - CNT_W'(1)));

  // Buffer data is only taken for a request this block actually issued
  assign pay_push = (state == PAY) & inflight & buf_data_av;
  assign last_hs  = (state == PAY) & pop & q_head.last;

  // Reads stay within the word budget, and occupancy plus inflight stays
  // at or below the queue depth; a pop this cycle frees a slot immediately
  assign rd_words_left = ((CNTX_W'(recv_cnt) + CNTX_W'(inflight)) < CNTX_W'(total_words));
  assign rd_space      = ((OCCX_W'(occ_after_pop) + OCCX_W'(inflight)) < OCCX_W'(2));

  // Byte enables for the final payload word
  always_comb begin
    last_keep = 4'b1111;
    case (len_q[1:0])
      2'd0:    last_keep = 4'b1111;
      2'd1:    last_keep = 4'b1000;
      2'd2:    last_keep = 4'b1100;
      default: last_keep = 4'b1110;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length datagram passes through PAY with no reads
  // and leaves when the header's last word is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = HDR0;
      HDR0: if (room) state_nxt = HDR1;
      HDR1: if (room) state_nxt = PAY;
      PAY:  if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state queue push and buffer read request
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    buf_rd_en  = 1'b0;
    case (state)
      HDR0: begin
        push            = room;
        push_entry.data = {src_q, dst_q};
        push_entry.keep = 4'b1111;
      end
      HDR1: begin
        push            = room;
        push_entry.data = {len_q + LEN_W'(UDP_HDR_BYTES), CHECKSUM_VALUE};
        push_entry.last = (len_q == '0);
        push_entry.keep = 4'b1111;
      end
      PAY: begin
        push            = pay_push;
        push_entry.data = buf_data;
        push_entry.last = last_pay;
        push_entry.keep = last_pay ? last_keep : 4'b1111;
        buf_rd_en       = rd_words_left & rd_space;
      end
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // Latched request fields, received-word counter, read-inflight flag
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      recv_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= buf_rd_en;
      if (start_ok) begin
        src_q    <= src_port;
        dst_q    <= dst_port;
        len_q    <= payload_len;
        recv_cnt <= '0;
      end else if (pay_push) begin
        recv_cnt <= recv_cnt + CNT_W'(1);
      end
    end
  end

  // Two-entry output queue; the head entry drives the output port directly.
  // On pop the tail shifts to head; a push lands at the first free slot
  // after that shift.
  assign occ_nxt = occ - OCC_W'(pop) + OCC_W'(push);

  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= '0;
      q_head    <= '0;
      q_tail    <= '0;
      out_valid <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != '0);
      if (pop) begin
        q_head <= q_tail;
      end
      if (push) begin
        if (occ_after_pop == '0) begin
          q_head <= push_entry;
        end else begin
          q_tail <= push_entry;
        end
      end
    end
  end

  assign out_data = q_head.data;
  assign out_last = q_head.last;
  assign out_keep = q_head.keep;

  // Status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err_len <= 1'b0;
    end else begin
      done    <= last_hs;
      err_len <= start_bad;
      if (start_ok) begin
        busy <= 1'b1;
      end else if (last_hs) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed testbench for udp_tx_framer. Expected words are queued when each
// datagram is requested and popped at every output handshake; a small
// buffer model answers reads one cycle later.
module tb_udp_tx_framer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] payload_len;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        buf_rd_en;
  logic [31:0] buf_data;
  logic        buf_data_av;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out_keep;

  udp_tx_framer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .src_port    (src_port),
    .dst_port    (dst_port),
    .payload_len (payload_len),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len),
    .buf_rd_en   (buf_rd_en),
    .buf_data    (buf_data),
    .buf_data_av (buf_data_av),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_keep    (out_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
    logic        hdr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] buf_mem[$];
  logic [31:0] late_q[$];
  bit          ready_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Values sampled on the falling edge of the most recent tick
  logic        s_valid, s_busy, s_done, s_err, s_rd, s_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;

  bit          sb_on;
  bit          exp_done;
  bit          last_seen;
  bit          rd_pend;
  bit          rd_prev;
  bit          prev_stall;
  logic [36:0] prev_word;
  int          rd_cnt;
  int          pay_in;
  int          pay_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keep_of(input logic [1:0] r);
    case (r)
      2'd0:    keep_of = 4'b1111;
      2'd1:    keep_of = 4'b1000;
      2'd2:    keep_of = 4'b1100;
      default: keep_of = 4'b1110;
    endcase
  endfunction

  // One clock: check at the falling edge, then drive the next cycle's inputs
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_valid = out_valid; s_busy = busy; s_done = done; s_err = err_len;
    s_rd = buf_rd_en; s_data = out_data; s_last = out_last; s_keep = out_keep;

    chk("done_pulse", 64'(done), 64'(exp_done));
    exp_done = 1'b0;

    if (sb_on && prev_stall)
      chk("stall_hold", 64'({out_valid, out_data, out_last, out_keep}), 64'({1'b1, prev_word}));
    prev_stall = out_valid & ~out_ready;
    prev_word  = {out_data, out_last, out_keep};

    if (sb_on) begin
      n_cmp++;
      assert ((pay_in - pay_out + int'(rd_prev)) <= 2) else begin
        n_bad++;
        $error("FAIL occ_bound: observed %0d expected <=2", pay_in - pay_out + int'(rd_prev));
      end
      if (buf_rd_en) rd_cnt++;
      if (buf_data_av) pay_in++;
    end

    if (sb_on && out_valid && out_ready) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL extra_word: observed %0h expected none", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("word", 64'({out_data, out_last, out_keep}), 64'({e.data, e.last, e.keep}));
        if (!e.hdr) pay_out++;
        if (e.last) begin
          exp_done  = 1'b1;
          last_seen = 1'b1;
        end
      end
    end

    rd_prev = buf_rd_en;
    rd_pend = buf_rd_en && (buf_mem.size() != 0);
    @(posedge clk);
    #1;
    if (rd_pend) begin
      buf_data    = buf_mem.pop_front();
      buf_data_av = 1'b1;
    end else begin
      buf_data    = 32'hDEAD_BEEF;
      buf_data_av = 1'b0;
    end
    out_ready = (ready_q.size() != 0) ? ready_q.pop_front() : 1'b1;
  endtask

  // Queue the expected datagram, stock the buffer, and pulse start
  task automatic send(input logic [15:0] src, input logic [15:0] dst,
                      input logic [15:0] len, input bit fill);
    int nw;
    exp_t e;
    logic [31:0] w;
    nw = (int'(len) + 3) / 4;
    e.data = {src, dst}; e.last = 1'b0; e.keep = 4'hF; e.hdr = 1'b1;
    exp_q.push_back(e);
    e.data = {len + 16'd8, 16'h0000}; e.last = (len == 16'd0);
    exp_q.push_back(e);
    for (int i = 0; i < nw; i++) begin
      w      = $urandom;
      e.data = w;
      e.last = (i == nw - 1);
      e.keep = (i == nw - 1) ? keep_of(len[1:0]) : 4'hF;
      e.hdr  = 1'b0;
      exp_q.push_back(e);
      if (fill) buf_mem.push_back(w);
      else late_q.push_back(w);
    end
    src_port = src; dst_port = dst; payload_len = len;
    last_seen = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_last(input int budget);
    int k;
    k = 0;
    while (!last_seen && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    assert (last_seen) else begin
      n_bad++;
      $error("FAIL timeout_last: observed %0d cycles expected last word", k);
    end
    chk("leftover", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clr_counts();
    rd_cnt = 0; pay_in = 0; pay_out = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_port = '0; dst_port = '0; payload_len = '0;
    buf_data = '0; buf_data_av = 1'b0; out_ready = 1'b1;
    sb_on = 1'b1; exp_done = 1'b0; last_seen = 1'b0; rd_pend = 1'b0;
    rd_prev = 1'b0; prev_stall = 1'b0; prev_word = '0;
    clr_counts();

    // Reset state
    repeat (3) tick();
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_err", 64'(s_err), 64'd0);
    chk("rst_rd", 64'(s_rd), 64'd0);
    chk("rst_data", 64'({s_data, s_last, s_keep}), 64'd0);
    reset = 1'b0;
    tick();

    // 1: len=8, two payload words, 2-cycle latency, two reads
    clr_counts();
    send(16'h1234, 16'h5678, 16'd8, 1'b1);
    tick();
    chk("t1_busy", 64'(s_busy), 64'd1);
    chk("t1_valid_early", 64'(s_valid), 64'd0);
    tick();
    chk("t1_latency", 64'(s_valid), 64'd1);
    chk("t1_hdr0", 64'(s_data), 64'h1234_5678);
    wait_last(50);
    tick();
    chk("t1_busy_done", 64'(s_busy), 64'd0);
    chk("t1_rd_cnt", 64'(rd_cnt), 64'd2);
    chk("t1_av_cnt", 64'(pay_in), 64'd2);

    // 2: len=5, partial last word; 3 is started in 2's done cycle
    clr_counts();
    send(16'h0400, 16'h0035, 16'd5, 1'b1);
    wait_last(50);
    clr_counts();
    send(16'hABCD, 16'h0001, 16'd0, 1'b1);
    chk("t2_busy_done", 64'(s_busy), 64'd0);
    chk("t2_done_seen", 64'(s_done), 64'd1);

    // 3: len=0, header only, no reads
    wait_last(50);
    tick();
    chk("t3_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("t3_busy", 64'(s_busy), 64'd0);

    // 4: len=64 under backpressure
    clr_counts();
    ready_q = '{1, 0, 1, 0};
    repeat (20) ready_q.push_back(1'b0);
    send(16'h1111, 16'h2222, 16'd64, 1'b1);
    wait_last(300);
    tick();
    chk("t4_av_cnt", 64'(pay_in), 64'd16);

    // 5: buffer empty at start, filled 10 cycles later
    clr_counts();
    send(16'h3333, 16'h4444, 16'd12, 1'b0);
    repeat (10) tick();
    while (late_q.size() != 0) buf_mem.push_back(late_q.pop_front());
    wait_last(100);
    tick();
    chk("t5_av_cnt", 64'(pay_in), 64'd3);
    n_cmp++;
    assert (rd_cnt > pay_in) else begin
      n_bad++;
      $error("FAIL t5_retry: observed %0d reads expected more than %0d", rd_cnt, pay_in);
    end

    // 6a: oversize request rejected
    payload_len = 16'd65508; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_err_pulse", 64'(s_err), 64'd1);
    chk("t6_err_busy", 64'(s_busy), 64'd0);
    chk("t6_err_valid", 64'(s_valid), 64'd0);
    tick();
    chk("t6_err_clear", 64'(s_err), 64'd0);
    chk("t6_err_novalid", 64'(s_valid), 64'd0);

    // 6b: maximum length accepted, then reset mid-payload
    sb_on = 1'b0;
    for (int i = 0; i < 6; i++) buf_mem.push_back(32'hC0DE_0000 + 32'(i));
    payload_len = 16'd65507; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_max_err", 64'(s_err), 64'd0);
    chk("t6_max_busy", 64'(s_busy), 64'd1);
    repeat (8) tick();
    chk("t6_mid_busy", 64'(s_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    buf_mem.delete();
    tick();
    chk("t6_rst_valid", 64'(s_valid), 64'd0);
    chk("t6_rst_busy", 64'(s_busy), 64'd0);
    repeat (3) tick();
    chk("t6_rst_rd", 64'(s_rd), 64'd0);
    buf_mem.delete();
    exp_q.delete();
    clr_counts();
    prev_stall = 1'b0;
    sb_on = 1'b1;
    send(16'h0BAD, 16'hF00D, 16'd7, 1'b1);
    wait_last(50);
    tick();
    chk("t6_clean_busy", 64'(s_busy), 64'd0);
    chk("t6_clean_av", 64'(pay_in), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
